// File: rtl/rotate_pkg.sv
// Constants shared with the rotate core, plus the round-robin pick function
// used by the channel arbiter.
package rotate_pkg;

    localparam int ROT_LATENCY_DEF = 4;
    localparam int PHASE_W_DEF     = 16;
    localparam int MAX_CH          = 8;

    // Returns the first asserted request after 'last', searching circularly.
    // The loop runs over MAX_CH so its bound is static; entries at or above
    // num_ch are ignored. Result is 0 when no request is asserted.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_CH-1:0] req,
        input logic [2:0]        last,
        input int                num_ch
    );
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = (int'(last) + i) % num_ch;
            if (!found && (i <= num_ch) && req[idx]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last winner
// that advances only when a grant is issued.
module rr_arbiter
    import rotate_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win,
    output logic          any
);

    logic [IW-1:0] last_q, last_d;
    logic [2:0]    pick;

    always_comb begin
        pick = rr_pick(MAX_CH'(req), 3'(last_q), N);
        any  = |req;
        win  = IW'(pick);
        gnt  = '0;
        for (int c = 0; c < N; c++) begin
            gnt[c] = any && (pick == 3'(c));
        end
        // Every grant goes to a requester, so any request is a transfer.
        last_d = any ? IW'(pick) : last_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rotate_ch_sched.sv
// Time-shares one rotate core among NUM_CH streams, each with its own phase
// accumulator; results are routed back by a tag pipeline matched to the core latency.
module rotate_ch_sched
    import rotate_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 16,
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int ROT_LATENCY = ROT_LATENCY_DEF,
    parameter int CW          = $clog2(NUM_CH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data_r,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data_i,
    input  logic [NUM_CH*PHASE_W-1:0] ch_freq,
    input  logic [NUM_CH-1:0]         ch_phase_clr,
    output logic [PHASE_W-1:0]        rot_phase,
    output logic                      rot_ivalid,
    output logic [DATA_W-1:0]         rot_idata_r,
    output logic [DATA_W-1:0]         rot_idata_i,
    input  logic                      rot_ovalid,
    input  logic [DATA_W-1:0]         rot_result_r,
    input  logic [DATA_W-1:0]         rot_result_i,
    output logic                      out_valid,
    output logic [CW-1:0]             out_ch,
    output logic [DATA_W-1:0]         out_r,
    output logic [DATA_W-1:0]         out_i,
    output logic                      tag_err
);

    logic [CW-1:0] win;
    logic          xfer;

    rr_arbiter #(.N(NUM_CH), .IW(CW)) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (ch_valid),
        .gnt   (ch_ready),
        .win   (win),
        .any   (xfer)
    );

    logic [PHASE_W-1:0] acc_q [NUM_CH];
    logic [PHASE_W-1:0] acc_d [NUM_CH];

    logic               rot_ivalid_q, rot_ivalid_d;
    logic [PHASE_W-1:0] rot_phase_q, rot_phase_d;
    logic [DATA_W-1:0]  rot_r_q, rot_r_d;
    logic [DATA_W-1:0]  rot_i_q, rot_i_d;
    logic [CW-1:0]      iss_ch_q, iss_ch_d;

    logic               tag_v_q  [ROT_LATENCY];
    logic               tag_v_d  [ROT_LATENCY];
    logic [CW-1:0]      tag_ch_q [ROT_LATENCY];
    logic [CW-1:0]      tag_ch_d [ROT_LATENCY];

    logic               out_valid_q, out_valid_d;
    logic [CW-1:0]      out_ch_q, out_ch_d;
    logic [DATA_W-1:0]  out_r_q, out_r_d;
    logic [DATA_W-1:0]  out_i_q, out_i_d;
    logic               tag_err_q, tag_err_d;

    logic [PHASE_W-1:0] sel_acc, sel_freq;
    logic [DATA_W-1:0]  sel_r, sel_i;
    logic               sel_clr;

    always_comb begin
        sel_acc  = '0;
        sel_freq = '0;
        sel_r    = '0;
        sel_i    = '0;
        sel_clr  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (win == CW'(c)) begin
                sel_acc  = acc_q[c];
                sel_freq = ch_freq[c*PHASE_W +: PHASE_W];
                sel_r    = ch_data_r[c*DATA_W +: DATA_W];
                sel_i    = ch_data_i[c*DATA_W +: DATA_W];
                sel_clr  = ch_phase_clr[c];
            end
        end
    end

    // A clear coinciding with a transfer issues phase 0 and restarts at one step.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = acc_q[c];
            if (xfer && (win == CW'(c))) begin
                acc_d[c] = ch_phase_clr[c] ? ch_freq[c*PHASE_W +: PHASE_W]
                                           : acc_q[c] + ch_freq[c*PHASE_W +: PHASE_W];
            end else if (ch_phase_clr[c]) begin
                acc_d[c] = '0;
            end
        end
    end

    always_comb begin
        rot_ivalid_d = xfer;
        rot_phase_d  = rot_phase_q;
        rot_r_d      = rot_r_q;
        rot_i_d      = rot_i_q;
        iss_ch_d     = iss_ch_q;
        if (xfer) begin
            rot_phase_d = sel_clr ? '0 : sel_acc;
            rot_r_d     = sel_r;
            rot_i_d     = sel_i;
            iss_ch_d    = win;
        end
    end

    // Stage 0 loads from the issue register, so the tail lines up with rot_ovalid.
    always_comb begin
        tag_v_d[0]  = rot_ivalid_q;
        tag_ch_d[0] = iss_ch_q;
        for (int k = 1; k < ROT_LATENCY; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_ch_d[k] = tag_ch_q[k-1];
        end
    end

    always_comb begin
        out_valid_d = rot_ovalid;
        out_ch_d    = out_ch_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        if (rot_ovalid) begin
            out_ch_d = tag_ch_q[ROT_LATENCY-1];
            out_r_d  = rot_result_r;
            out_i_d  = rot_result_i;
        end
        tag_err_d = tag_err_q | (rot_ovalid != tag_v_q[ROT_LATENCY-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
            rot_ivalid_q <= 1'b0;
            rot_phase_q  <= '0;
            rot_r_q      <= '0;
            rot_i_q      <= '0;
            iss_ch_q     <= '0;
            for (int k = 0; k < ROT_LATENCY; k++) begin
                tag_v_q[k]  <= 1'b0;
                tag_ch_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
            rot_ivalid_q <= rot_ivalid_d;
            rot_phase_q  <= rot_phase_d;
            rot_r_q      <= rot_r_d;
            rot_i_q      <= rot_i_d;
            iss_ch_q     <= iss_ch_d;
            for (int k = 0; k < ROT_LATENCY; k++) begin
                tag_v_q[k]  <= tag_v_d[k];
                tag_ch_q[k] <= tag_ch_d[k];
            end
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign rot_ivalid  = rot_ivalid_q;
    assign rot_phase   = rot_phase_q;
    assign rot_idata_r = rot_r_q;
    assign rot_idata_i = rot_i_q;
    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
    assign out_r       = out_r_q;
    assign out_i       = out_i_q;
    assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_rotate_ch_sched.sv
// Bench for rotate_ch_sched with the core modelled as a pure ROT_LATENCY delay;
// expected results are queued on each transfer and popped when due.
module tb_rotate_ch_sched;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int PW  = 16;
    localparam int L   = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NCH-1:0]     ch_valid = '0;
    logic [NCH-1:0]     ch_ready;
    logic [NCH*DW-1:0]  ch_data_r = '0;
    logic [NCH*DW-1:0]  ch_data_i = '0;
    logic [NCH*PW-1:0]  ch_freq = '0;
    logic [NCH-1:0]     ch_phase_clr = '0;
    logic [PW-1:0]      rot_phase;
    logic               rot_ivalid;
    logic [DW-1:0]      rot_idata_r, rot_idata_i;
    logic               rot_ovalid;
    logic [DW-1:0]      rot_result_r, rot_result_i;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic [DW-1:0]      out_r, out_i;
    logic               tag_err;
    logic               inj = 1'b0;

    rotate_ch_sched #(.NUM_CH(NCH), .DATA_W(DW), .PHASE_W(PW), .ROT_LATENCY(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .ch_data_r    (ch_data_r),
        .ch_data_i    (ch_data_i),
        .ch_freq      (ch_freq),
        .ch_phase_clr (ch_phase_clr),
        .rot_phase    (rot_phase),
        .rot_ivalid   (rot_ivalid),
        .rot_idata_r  (rot_idata_r),
        .rot_idata_i  (rot_idata_i),
        .rot_ovalid   (rot_ovalid),
        .rot_result_r (rot_result_r),
        .rot_result_i (rot_result_i),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_r        (out_r),
        .out_i        (out_i),
        .tag_err      (tag_err)
    );

    always #5 clock = ~clock;

    // Core model: pure delay line, cleared by the shared reset.
    logic          core_v [L];
    logic [DW-1:0] core_r [L];
    logic [DW-1:0] core_i [L];

    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < L; k++) begin
                core_v[k] <= 1'b0;
                core_r[k] <= '0;
                core_i[k] <= '0;
            end
        end else begin
            core_v[0] <= rot_ivalid;
            core_r[0] <= rot_idata_r;
            core_i[0] <= rot_idata_i;
            for (int k = 1; k < L; k++) begin
                core_v[k] <= core_v[k-1];
                core_r[k] <= core_r[k-1];
                core_i[k] <= core_i[k-1];
            end
        end
    end

    assign rot_ovalid   = core_v[L-1] | inj;
    assign rot_result_r = core_r[L-1];
    assign rot_result_i = core_i[L-1];

    typedef struct {
        int          ch;
        logic [15:0] r;
        logic [15:0] i;
        int          due;
    } sb_t;

    sb_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          m_last  = NCH - 1;
    logic [15:0] m_acc  [NCH];
    logic [15:0] freq   [NCH];
    int          gcnt   [NCH];
    logic        exp_iv  = 1'b0;
    logic [15:0] exp_ph  = '0;
    logic [15:0] exp_r   = '0;
    logic [15:0] exp_i   = '0;
    logic        exp_tag = 1'b0;
    int          spur_due = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_model(input logic [NCH-1:0] v, input int last);
        for (int i = 1; i <= NCH; i++) begin
            int idx;
            idx = (last + i) % NCH;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        sb_t e;
        chk("rot_ivalid", rot_ivalid, exp_iv);
        chk("rot_phase", rot_phase, exp_ph);
        chk("rot_idata_r", rot_idata_r, exp_r);
        chk("rot_idata_i", rot_idata_i, exp_i);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("out_valid", out_valid, 1);
            chk("out_ch", out_ch, e.ch);
            chk("out_r", out_r, e.r);
            chk("out_i", out_i, e.i);
        end else if (spur_due == cyc) begin
            chk("out_valid_spur", out_valid, 1);
        end else begin
            chk("out_valid_idle", out_valid, 0);
        end
        chk("tag_err", tag_err, exp_tag);
    endtask

    task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] clr, input logic do_inj);
        logic [15:0] dr [NCH];
        logic [15:0] di [NCH];
        logic [NCH-1:0] eg;
        int w;
        sb_t e;
        check_outputs();
        for (int c = 0; c < NCH; c++) begin
            dr[c] = 16'($urandom);
            di[c] = 16'($urandom);
            ch_data_r[c*DW +: DW] = dr[c];
            ch_data_i[c*DW +: DW] = di[c];
            ch_freq[c*PW +: PW]   = freq[c];
        end
        ch_valid     = v;
        ch_phase_clr = clr;
        inj          = do_inj;
        #1;
        w  = rr_model(v, m_last);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("ch_ready", ch_ready, eg);
        if (w >= 0) begin
            exp_iv = 1'b1;
            exp_ph = clr[w] ? 16'h0 : m_acc[w];
            exp_r  = dr[w];
            exp_i  = di[w];
            e.ch = w; e.r = dr[w]; e.i = di[w]; e.due = cyc + L + 2;
            sb.push_back(e);
            gcnt[w]++;
            m_last = w;
        end else begin
            exp_iv = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (c == w) m_acc[c] = (clr[c] ? 16'h0 : m_acc[c]) + freq[c];
            else if (clr[c]) m_acc[c] = 16'h0;
        end
        if (do_inj) spur_due = cyc + 1;
        @(posedge clock);
        #1;
        cyc++;
        if (do_inj) exp_tag = 1'b1;
        inj = 1'b0;
    endtask

    task automatic do_reset();
        ch_valid     = '0;
        ch_phase_clr = '0;
        reset        = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
        reset = 1'b0;
        sb.delete();
        for (int c = 0; c < NCH; c++) m_acc[c] = 16'h0;
        m_last   = NCH - 1;
        exp_iv   = 1'b0;
        exp_ph   = '0;
        exp_r    = '0;
        exp_i    = '0;
        exp_tag  = 1'b0;
        spur_due = -1;
        chk("rst_rot_ivalid", rot_ivalid, 0);
        chk("rst_rot_phase", rot_phase, 0);
        chk("rst_rot_idata_r", rot_idata_r, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_tag_err", tag_err, 0);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            freq[c]  = 16'h0;
            m_acc[c] = 16'h0;
            gcnt[c]  = 0;
        end
        repeat (2) @(posedge clock);
        do_reset();

        // Single channel, 5 back-to-back samples at freq 100.
        freq[0] = 16'd100;
        repeat (5) cycle(4'b0001, 4'b0000, 1'b0);
        repeat (8) cycle(4'b0000, 4'b0000, 1'b0);

        // Phase wrap on channel 2.
        freq[2] = 16'h4000;
        repeat (5) cycle(4'b0100, 4'b0000, 1'b0);
        repeat (8) cycle(4'b0000, 4'b0000, 1'b0);

        // Clear with transfer on channel 1 while its accumulator is 0x1234.
        freq[1] = 16'h1234;
        cycle(4'b0010, 4'b0010, 1'b0);
        freq[1] = 16'd10;
        cycle(4'b0010, 4'b0010, 1'b0);
        chk("clr_issue_phase", exp_ph, 0);
        cycle(4'b0010, 4'b0000, 1'b0);
        chk("clr_acc_model", m_acc[1], 16'd20);
        // Clear without transfer, then a transfer from the cleared channel.
        cycle(4'b0000, 4'b0010, 1'b0);
        cycle(4'b0010, 4'b0000, 1'b0);
        repeat (8) cycle(4'b0000, 4'b0000, 1'b0);

        // All channels continuously valid for 100 grants.
        for (int c = 0; c < NCH; c++) begin
            gcnt[c] = 0;
            freq[c] = 16'(c * 16'h0111 + 7);
        end
        repeat (100) cycle(4'b1111, 4'b0000, 1'b0);
        for (int c = 0; c < NCH; c++) chk($sformatf("fair_cnt%0d", c), gcnt[c], 25);
        repeat (8) cycle(4'b0000, 4'b0000, 1'b0);

        // Mixed random requests and clears.
        for (int n = 0; n < 60; n++) begin
            cycle(4'($urandom), (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000), 1'b0);
        end
        repeat (8) cycle(4'b0000, 4'b0000, 1'b0);

        // Reset mid-flight: in-flight samples must never appear.
        repeat (3) cycle(4'b0001, 4'b0000, 1'b0);
        do_reset();
        repeat (8) cycle(4'b0000, 4'b0000, 1'b0);

        // Spurious rot_ovalid with an empty tag pipeline.
        cycle(4'b0000, 4'b0000, 1'b1);
        repeat (6) cycle(4'b0000, 4'b0000, 1'b0);
        do_reset();
        repeat (2) cycle(4'b0000, 4'b0000, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
